// File: rtl/piton_pronoc_vc_mux_bridge.sv
// Multiplexes NUM_CH piton valid/yummy channels onto one ProNoC link, one VC per channel.
// Each channel has its own FIFO, packet-framing state and downstream credit counter.
module piton_pronoc_vc_mux_bridge #(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_W       = 8,
  parameter int LEN_LSB     = 22,
  parameter int CREDIT_INIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] dataIn,
  input  logic [NUM_CH-1:0]        validIn,
  output logic [NUM_CH-1:0]        yummyOut,
  output logic [DATA_W-1:0]        flit_o,
  output logic                     hdr_o,
  output logic                     tail_o,
  output logic [NUM_CH-1:0]        vc_o,
  output logic                     flit_wr_o,
  input  logic [NUM_CH-1:0]        credit_i,
  output logic [NUM_CH-1:0]        err_o
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(CREDIT_INIT + 1);
  localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] mem_r    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r [NUM_CH];
  logic [AW-1:0]     rd_ptr_r [NUM_CH];
  logic [CNT_W-1:0]  cnt_r    [NUM_CH];
  logic              body_r   [NUM_CH];
  logic [LEN_W-1:0]  rem_r    [NUM_CH];
  logic [CW-1:0]     credit_r [NUM_CH];
  logic [PW-1:0]     ptr_r;

  logic [NUM_CH-1:0] eligible_s;
  logic [NUM_CH-1:0] pop_s;
  logic [NUM_CH-1:0] push_s;
  logic              grant_valid_s;
  logic [PW-1:0]     grant_idx_s;
  logic [DATA_W-1:0] head_flit_s;
  logic [LEN_W-1:0]  len_s;
  logic              hdr_s;
  logic              tail_s;

  // Eligibility, push acceptance and pop decode per channel.
  always_comb begin
    eligible_s = '0;
    push_s     = '0;
    pop_s      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible_s[c] = (cnt_r[c] != CNT_W'(0)) && (credit_r[c] != CW'(0));
      pop_s[c]      = grant_valid_s && (grant_idx_s == PW'(c));
      push_s[c]     = validIn[c] && ((cnt_r[c] != CNT_W'(FIFO_DEPTH)) || pop_s[c]);
    end
  end

  // Round-robin search from ptr_r; scanning downward leaves the nearest eligible index.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible_s[(int'(ptr_r) + i) % NUM_CH]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = PW'((int'(ptr_r) + i) % NUM_CH);
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Framing flags for the flit at the head of the granted channel.
  always_comb begin
    head_flit_s = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
    len_s       = head_flit_s[LEN_LSB +: LEN_W];
    if (body_r[grant_idx_s]) begin
      hdr_s  = 1'b0;
      tail_s = (rem_r[grant_idx_s] == LEN_W'(1));
    end else begin
      hdr_s  = 1'b1;
      tail_s = (len_s == LEN_W'(0));
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_s[c]) begin
        mem_r[c][wr_ptr_r[c]] <= dataIn[c*DATA_W +: DATA_W];
      end
    end
  end

  // Per-channel FIFO pointers, packet state, credits and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        cnt_r[c]    <= '0;
        body_r[c]   <= 1'b0;
        rem_r[c]    <= '0;
        credit_r[c] <= CW'(CREDIT_INIT);
      end
      err_o <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + AW'(1);
        end
        if (pop_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + AW'(1);
        end
        case ({push_s[c], pop_s[c]})
          2'b10:   cnt_r[c] <= cnt_r[c] + CNT_W'(1);
          2'b01:   cnt_r[c] <= cnt_r[c] - CNT_W'(1);
          default: cnt_r[c] <= cnt_r[c];
        endcase
        if (validIn[c] && !push_s[c]) begin
          err_o[c] <= 1'b1;
        end
        if (pop_s[c]) begin
          if (!body_r[c]) begin
            if (len_s != LEN_W'(0)) begin
              body_r[c] <= 1'b1;
              rem_r[c]  <= len_s;
            end
          end else begin
            rem_r[c] <= rem_r[c] - LEN_W'(1);
            if (rem_r[c] == LEN_W'(1)) begin
              body_r[c] <= 1'b0;
            end
          end
        end
        // A return at full credit is only an overflow when no grant consumes one that cycle.
        case ({credit_i[c], pop_s[c]})
          2'b10: begin
            if (credit_r[c] == CW'(CREDIT_INIT)) begin
              err_o[c] <= 1'b1;
            end else begin
              credit_r[c] <= credit_r[c] + CW'(1);
            end
          end
          2'b01:   credit_r[c] <= credit_r[c] - CW'(1);
          default: credit_r[c] <= credit_r[c];
        endcase
      end
    end
  end

  // Registered ProNoC output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r     <= '0;
      flit_o    <= '0;
      hdr_o     <= 1'b0;
      tail_o    <= 1'b0;
      vc_o      <= '0;
      flit_wr_o <= 1'b0;
      yummyOut  <= '0;
    end else begin
      flit_wr_o <= grant_valid_s;
      yummyOut  <= pop_s;
      if (grant_valid_s) begin
        flit_o <= head_flit_s;
        hdr_o  <= hdr_s;
        tail_o <= tail_s;
        vc_o   <= pop_s;
        ptr_r  <= (grant_idx_s == PW'(NUM_CH - 1)) ? PW'(0) : grant_idx_s + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piton_pronoc_vc_mux_bridge.sv
// Directed plus random bench for piton_pronoc_vc_mux_bridge against a queue-based reference.
module tb_piton_pronoc_vc_mux_bridge;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int D  = 4;
  localparam int LW = 8;
  localparam int LL = 22;
  localparam int CI = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*DW-1:0] dataIn = '0;
  logic [N-1:0]    validIn = '0;
  logic [N-1:0]    yummyOut;
  logic [DW-1:0]   flit_o;
  logic            hdr_o, tail_o, flit_wr_o;
  logic [N-1:0]    vc_o;
  logic [N-1:0]    credit_i = '0;
  logic [N-1:0]    err_o;

  piton_pronoc_vc_mux_bridge #(.NUM_CH(N), .DATA_W(DW), .FIFO_DEPTH(D), .LEN_W(LW),
    .LEN_LSB(LL), .CREDIT_INIT(CI)) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .yummyOut(yummyOut),
    .flit_o(flit_o), .hdr_o(hdr_o), .tail_o(tail_o), .vc_o(vc_o), .flit_wr_o(flit_wr_o),
    .credit_i(credit_i), .err_o(err_o));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  logic [DW-1:0] mq [N][$];
  int            mcred [N];
  int            mrem [N];
  int            mptr;
  logic [N-1:0]  merr;
  logic [DW-1:0] e_flit;
  logic          e_hdr, e_tail, e_wr;
  logic [N-1:0]  e_vc, e_yum;

  // stimulus sources
  logic [DW-1:0] src_q [N][$];
  logic [N-1:0]  cr_pend = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_edge();
    int g;
    int len;
    int pre_cred [N];
    logic [DW-1:0] f;
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        mq[c].delete();
        mcred[c] = CI;
        mrem[c] = 0;
      end
      mptr = 0; merr = '0; e_flit = '0; e_hdr = 1'b0; e_tail = 1'b0;
      e_wr = 1'b0; e_vc = '0; e_yum = '0;
      return;
    end
    g = -1;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (mptr + i) % N;
      if (g < 0 && mq[idx].size() > 0 && mcred[idx] > 0) g = idx;
    end
    for (int c = 0; c < N; c++) pre_cred[c] = mcred[c];
    e_wr = 1'b0; e_yum = '0;
    if (g >= 0) begin
      f = mq[g].pop_front();
      e_flit = f; e_vc = N'(1) << g; e_wr = 1'b1; e_yum[g] = 1'b1;
      if (mrem[g] == 0) begin
        len = int'(f[LL +: LW]);
        e_hdr = 1'b1; e_tail = (len == 0); mrem[g] = len;
      end else begin
        e_hdr = 1'b0; e_tail = (mrem[g] == 1); mrem[g]--;
      end
      mcred[g]--;
      mptr = (g + 1) % N;
    end
    for (int c = 0; c < N; c++) begin
      if (credit_i[c]) begin
        if (pre_cred[c] == CI && g != c) merr[c] = 1'b1;
        else mcred[c]++;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (validIn[c]) begin
        if (mq[c].size() < D) mq[c].push_back(dataIn[c*DW +: DW]);
        else merr[c] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("flit_wr", 64'(flit_wr_o), 64'(e_wr));
    chk("yummy", 64'(yummyOut), 64'(e_yum));
    chk("vc", 64'(vc_o), 64'(e_vc));
    chk("hdr", 64'(hdr_o), 64'(e_hdr));
    chk("tail", 64'(tail_o), 64'(e_tail));
    chk("flit", flit_o, e_flit);
    chk("err", 64'(err_o), 64'(merr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic feed(input bit rnd);
    validIn = '0;
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() > 0 && (!rnd || (mq[c].size() < D && $urandom_range(3) != 0))) begin
        validIn[c] = 1'b1;
        dataIn[c*DW +: DW] = src_q[c].pop_front();
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      feed(1'b0);
      credit_i = cr_pend;
      cr_pend = '0;
      step();
    end
    validIn = '0;
    credit_i = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic add_pkt(input int c, input int len);
    logic [DW-1:0] h;
    h = {$urandom, $urandom};
    h[LL +: LW] = LW'(len);
    src_q[c].push_back(h);
    for (int i = 0; i < len; i++) src_q[c].push_back({$urandom, $urandom});
  endtask

  initial begin
    // reset held with all channels valid
    validIn = '1;
    dataIn = {N{64'hDEAD_BEEF_0000_0001}};
    do_reset(3);
    validIn = '0;
    run(4);

    // single 3-flit packet on ch0
    add_pkt(0, 2);
    run(6);

    // single-flit packet on ch2
    add_pkt(2, 0);
    run(4);

    // three simultaneous 4-flit packets, interleaved by VC
    do_reset(2);
    add_pkt(0, 3); add_pkt(1, 3); add_pkt(2, 3);
    run(16);

    // credit exhaustion on ch1, then release one credit at a time
    do_reset(2);
    add_pkt(1, 5);
    run(12);
    cr_pend = 3'b010;
    run(4);
    cr_pend = 3'b010;
    run(4);

    // FIFO overflow on ch0 after draining its credits, then spurious credit on ch2
    do_reset(2);
    add_pkt(0, 3);
    run(8);
    add_pkt(0, 4);
    run(7);
    cr_pend = 3'b100;
    run(2);
    for (int k = 0; k < 4; k++) begin
      cr_pend = 3'b001;
      run(2);
    end
    run(4);

    // randomized traffic with random credit returns
    do_reset(2);
    repeat (500) begin
      for (int c = 0; c < N; c++)
        if (src_q[c].size() == 0 && $urandom_range(2) == 0) add_pkt(c, $urandom_range(6));
      feed(1'b1);
      for (int c = 0; c < N; c++) credit_i[c] = (mcred[c] < CI) && ($urandom_range(1) == 1);
      step();
    end
    validIn = '0;
    credit_i = '0;
    run(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
